// File: rtl/imem_if.sv
// Instruction-memory read bus: request/grant address phase, rvalid data phase.
interface imem_if #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned INSTR_W = 32
);
   logic               req;
   logic [ADDR_W-1:0]  addr;
   logic               gnt;
   logic               rvalid;
   logic [INSTR_W-1:0] rdata;

   // Fetch unit side: issues the read and consumes the response.
   modport master (
      output req,
      output addr,
      input  gnt,
      input  rvalid,
      input  rdata
   );

   // Memory side: accepts the read and returns the instruction word.
   modport slave (
      input  req,
      input  addr,
      output gnt,
      output rvalid,
      output rdata
   );
endinterface : imem_if

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the architectural PC, applies jump/branch redirects and
// performs one instruction-memory read per PC_en pulse. fetch_busy lets the
// control FSM hold in its PC state until instr_valid delivers the instruction.
// A read that sees no rvalid within TIMEOUT cycles of grant is abandoned, a
// NOP is delivered in its place and the sticky fetch_err flag is raised.
// TIMEOUT must lie in 2..255 (the response counter is 8 bits wide).
module instr_fetch_unit #(
   parameter int unsigned        ADDR_W    = 32,
   parameter int unsigned        INSTR_W   = 32,
   parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
   parameter int unsigned        TIMEOUT   = 16,
   parameter logic [INSTR_W-1:0] NOP_INSTR = 'h13
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               PC_en,
   input  logic               Jump_en,
   input  logic [ADDR_W-1:0]  jump_target,
   input  logic               EXPC_en,
   input  logic               branch_taken,
   input  logic [ADDR_W-1:0]  branch_target,
   imem_if.master             imem,
   output logic [ADDR_W-1:0]  pc,
   output logic [ADDR_W-1:0]  pc_plus4,
   output logic [INSTR_W-1:0] instr,
   output logic               instr_valid,
   output logic               fetch_busy,
   output logic               fetch_err
);

   localparam int unsigned      CNT_W    = 8;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT
   } state_e;

   state_e              state_q,       state_d;
   logic [CNT_W-1:0]    cnt_q,         cnt_d;
   logic [ADDR_W-1:0]   fetch_ptr_q,   fetch_ptr_d;
   logic                redir_pend_q,  redir_pend_d;
   logic [ADDR_W-1:0]   redir_addr_q,  redir_addr_d;
   logic                req_q,         req_d;
   logic [ADDR_W-1:0]   addr_q,        addr_d;
   logic [ADDR_W-1:0]   pc_q,          pc_d;
   logic [ADDR_W-1:0]   pc_plus4_q,    pc_plus4_d;
   logic [INSTR_W-1:0]  instr_q,       instr_d;
   logic                instr_valid_q, instr_valid_d;
   logic                busy_q,        busy_d;
   logic                err_q,         err_d;

   logic                redir_hit;
   logic [ADDR_W-1:0]   redir_new;
   logic                redir_eff_pend;
   logic [ADDR_W-1:0]   redir_eff_addr;
   logic [ADDR_W-1:0]   fetch_addr;
   logic                fetch_start;
   logic                granted;
   logic                rsp_ok;
   logic                rsp_tmo;
   logic                fetch_done;
   logic [ADDR_W-1:0]   next_seq;

   // Resolve this cycle's redirect against the pending one; a redirect seen
   // in the same cycle as PC_en is bypassed straight into the fetch address.
   always_comb begin
      redir_hit      = Jump_en | (EXPC_en & branch_taken);
      redir_new      = Jump_en ? jump_target : branch_target;
      redir_eff_pend = redir_hit | redir_pend_q;
      redir_eff_addr = redir_hit ? redir_new : redir_addr_q;
      fetch_addr     = redir_eff_pend ? redir_eff_addr : fetch_ptr_q;
   end

   // Handshake events that drive both the state and the datapath.
   always_comb begin
      fetch_start = (state_q == S_IDLE) & PC_en;
      granted     = (state_q == S_REQ)  & imem.gnt;
      rsp_ok      = (state_q == S_WAIT) & imem.rvalid;
      rsp_tmo     = (state_q == S_WAIT) & ~imem.rvalid & (cnt_q == CNT_LAST);
      fetch_done  = rsp_ok | rsp_tmo;
      next_seq    = addr_q + ADDR_STEP;
   end

   // Next-state logic: IDLE -> REQ on PC_en, REQ -> WAIT on grant,
   // WAIT -> IDLE on rvalid or timeout. PC_en while busy is dropped.
   always_comb begin
      // NOTE: every comb output gets a default first so no path infers a latch.
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (fetch_start) state_d = S_REQ;
         S_REQ:   if (granted)     state_d = S_WAIT;
         S_WAIT:  if (fetch_done)  state_d = S_IDLE;
         default:                  state_d = S_IDLE;
      endcase
   end

   // Datapath and output register updates for each handshake event.
   always_comb begin
      cnt_d         = cnt_q;
      fetch_ptr_d   = fetch_ptr_q;
      redir_pend_d  = redir_eff_pend;
      redir_addr_d  = redir_eff_addr;
      req_d         = req_q;
      addr_d        = addr_q;
      pc_d          = pc_q;
      pc_plus4_d    = pc_plus4_q;
      instr_d       = instr_q;
      instr_valid_d = 1'b0;
      busy_d        = busy_q;
      err_d         = err_q;

      if (fetch_start) begin
         req_d        = 1'b1;
         addr_d       = fetch_addr;
         redir_pend_d = 1'b0;
         busy_d       = 1'b1;
      end

      if (granted) begin
         req_d = 1'b0;
         cnt_d = '0;
      end

      if (state_q == S_WAIT) begin
         cnt_d = cnt_q + CNT_W'(1);
      end

      // Success and timeout both retire the fetch; only the payload differs.
      if (fetch_done) begin
         instr_d       = rsp_ok ? imem.rdata : NOP_INSTR;
         pc_d          = addr_q;
         pc_plus4_d    = next_seq;
         fetch_ptr_d   = next_seq;
         instr_valid_d = 1'b1;
         busy_d        = 1'b0;
      end

      if (rsp_tmo) begin
         err_d = 1'b1;
      end
   end

   // State and datapath registers with synchronous reset; reset cancels any
   // in-flight read and discards a pending redirect.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         fetch_ptr_q   <= RESET_PC;
         redir_pend_q  <= 1'b0;
         redir_addr_q  <= '0;
         req_q         <= 1'b0;
         addr_q        <= '0;
         pc_q          <= RESET_PC;
         pc_plus4_q    <= RESET_PC + ADDR_STEP;
         instr_q       <= NOP_INSTR;
         instr_valid_q <= 1'b0;
         busy_q        <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         fetch_ptr_q   <= fetch_ptr_d;
         redir_pend_q  <= redir_pend_d;
         redir_addr_q  <= redir_addr_d;
         req_q         <= req_d;
         addr_q        <= addr_d;
         pc_q          <= pc_d;
         pc_plus4_q    <= pc_plus4_d;
         instr_q       <= instr_d;
         instr_valid_q <= instr_valid_d;
         busy_q        <= busy_d;
         err_q         <= err_d;
      end
   end

   assign imem.req    = req_q;
   assign imem.addr   = addr_q;
   assign pc          = pc_q;
   assign pc_plus4    = pc_plus4_q;
   assign instr       = instr_q;
   assign instr_valid = instr_valid_q;
   assign fetch_busy  = busy_q;
   assign fetch_err   = err_q;

endmodule : instr_fetch_unit

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit. Inputs are driven and outputs
// sampled on the falling clock edge. The reference model tracks the fetch
// pointer, the pending redirect and the retired PC/instruction per transaction.
module tb_instr_fetch_unit;

   localparam int          TIMEOUT  = 16;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        PC_en;
   logic        Jump_en;
   logic [31:0] jump_target;
   logic        EXPC_en;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic [31:0] instr;
   logic        instr_valid;
   logic        fetch_busy;
   logic        fetch_err;

   imem_if #(.ADDR_W(32), .INSTR_W(32)) bus ();

   instr_fetch_unit #(
      .ADDR_W    (32),
      .INSTR_W   (32),
      .RESET_PC  (RESET_PC),
      .TIMEOUT   (TIMEOUT),
      .NOP_INSTR (NOP)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .PC_en         (PC_en),
      .Jump_en       (Jump_en),
      .jump_target   (jump_target),
      .EXPC_en       (EXPC_en),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .imem          (bus),
      .pc            (pc),
      .pc_plus4      (pc_plus4),
      .instr         (instr),
      .instr_valid   (instr_valid),
      .fetch_busy    (fetch_busy),
      .fetch_err     (fetch_err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state.
   logic [31:0] m_ptr;
   logic        m_pend;
   logic [31:0] m_paddr;
   logic [31:0] m_pc;
   logic [31:0] m_instr;
   logic        m_err;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_ptr   = RESET_PC;
      m_pend  = 1'b0;
      m_paddr = '0;
      m_pc    = RESET_PC;
      m_instr = NOP;
      m_err   = 1'b0;
   endtask

   task automatic clear_inputs();
      PC_en         = 1'b0;
      Jump_en       = 1'b0;
      jump_target   = $urandom;
      EXPC_en       = 1'b0;
      branch_taken  = 1'b0;
      branch_target = $urandom;
      bus.gnt       = 1'b0;
      bus.rvalid    = 1'b0;
      bus.rdata     = $urandom;
   endtask

   // Drive a redirect for the next edge and record it in the model:
   // a jump beats a taken branch, and a newer redirect replaces an older one.
   task automatic drive_redirect(input logic j, input logic [31:0] jt,
                                 input logic b, input logic tk, input logic [31:0] bt);
      Jump_en       = j;
      jump_target   = jt;
      EXPC_en       = b;
      branch_taken  = tk;
      branch_target = bt;
      if (j) begin
         m_pend  = 1'b1;
         m_paddr = jt;
      end else if (b && tk) begin
         m_pend  = 1'b1;
         m_paddr = bt;
      end
   endtask

   task automatic idle_cycle(input logic j, input logic [31:0] jt,
                             input logic b, input logic tk, input logic [31:0] bt);
      drive_redirect(j, jt, b, tk, bt);
      @(negedge clk);
      clear_inputs();
      check("idle_busy", 32'(fetch_busy), 32'd0);
      check("idle_valid", 32'(instr_valid), 32'd0);
   endtask

   // One complete fetch. g = cycles of grant delay, rv = cycles from the first
   // WAIT cycle to rvalid (negative = never). spam adds ignored PC_en pulses and
   // stray rvalid during the address phase; noise adds redirects while busy.
   task automatic fetch(input logic j, input logic [31:0] jt,
                        input logic b, input logic tk, input logic [31:0] bt,
                        input int g, input int rv, input logic [31:0] data,
                        input bit spam, input bit noise);
      bit          tmo;
      int          rv_eff;
      int          lat;
      int          last_t;
      logic [31:0] a;
      tmo    = (rv < 0) || (rv > TIMEOUT - 1);
      rv_eff = tmo ? TIMEOUT - 1 : rv;
      lat    = 3 + g + rv_eff;
      last_t = lat + 2;
      if (rv >= 0 && (2 + g + rv + 2) > last_t) last_t = 2 + g + rv + 2;

      drive_redirect(j, jt, b, tk, bt);
      PC_en  = 1'b1;
      a      = m_pend ? m_paddr : m_ptr;
      m_pend = 1'b0;

      for (int t = 1; t <= last_t; t++) begin
         @(negedge clk);
         clear_inputs();
         if (t == lat) begin
            m_pc    = a;
            m_ptr   = a + 32'd4;
            m_instr = tmo ? NOP : data;
            if (tmo) m_err = 1'b1;
         end
         check("imem_req", 32'(bus.req), 32'(t <= 1 + g));
         if (t <= 1 + g) check("imem_addr", bus.addr, a);
         check("fetch_busy", 32'(fetch_busy), 32'(t < lat));
         check("instr_valid", 32'(instr_valid), 32'(t == lat));
         check("pc", pc, m_pc);
         check("pc_plus4", pc_plus4, m_pc + 32'd4);
         check("instr", instr, m_instr);
         check("fetch_err", 32'(fetch_err), 32'(m_err));

         if (t == 1 + g) bus.gnt = 1'b1;
         if (rv >= 0 && t == 2 + g + rv) begin
            bus.rvalid = 1'b1;
            bus.rdata  = data;
         end
         if (t < lat) begin
            if (spam && $urandom_range(0, 1) == 0) PC_en = 1'b1;
            if (spam && t <= 1 + g && $urandom_range(0, 2) == 0) bus.rvalid = 1'b1;
            if (noise && $urandom_range(0, 3) == 0)
               drive_redirect(1'($urandom_range(0, 1)), $urandom,
                              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
         end
      end
   endtask

   // Reset lands while the read is in WAIT with a redirect pending; a stale
   // rvalid two edges later must not produce an instruction.
   task automatic reset_mid_fetch();
      PC_en  = 1'b1;
      m_pend = 1'b0;
      @(negedge clk);
      clear_inputs();
      check("rst_req_issued", 32'(bus.req), 32'd1);
      bus.gnt = 1'b1;
      drive_redirect(1'b1, 32'h0000_0500, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      clear_inputs();
      check("rst_in_wait_busy", 32'(fetch_busy), 32'd1);
      check("rst_in_wait_req", 32'(bus.req), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      check("rst_mid_req", 32'(bus.req), 32'd0);
      check("rst_mid_addr", bus.addr, 32'd0);
      check("rst_mid_pc", pc, RESET_PC);
      check("rst_mid_pc4", pc_plus4, RESET_PC + 32'd4);
      check("rst_mid_instr", instr, NOP);
      check("rst_mid_busy", 32'(fetch_busy), 32'd0);
      check("rst_mid_err", 32'(fetch_err), 32'd0);
      check("rst_mid_valid", 32'(instr_valid), 32'd0);
      @(negedge clk);
      bus.rvalid = 1'b1;
      bus.rdata  = 32'hBAD0_BAD0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         clear_inputs();
         check("stale_rvalid_valid", 32'(instr_valid), 32'd0);
         check("stale_rvalid_instr", instr, NOP);
         check("stale_rvalid_busy", 32'(fetch_busy), 32'd0);
      end
   endtask

   initial begin
      clear_inputs();
      model_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("reset_pc", pc, RESET_PC);
      check("reset_pc4", pc_plus4, RESET_PC + 32'd4);
      check("reset_instr", instr, NOP);
      check("reset_valid", 32'(instr_valid), 32'd0);
      check("reset_req", 32'(bus.req), 32'd0);
      check("reset_addr", bus.addr, 32'd0);
      check("reset_busy", 32'(fetch_busy), 32'd0);
      check("reset_err", 32'(fetch_err), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Basic fetch, then sequential follow-on.
      fetch(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 0, 0, 32'hDEAD_BEEF, 1'b0, 1'b0);
      fetch(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 0, 0, 32'h1111_2222, 1'b0, 1'b0);

      // Jump and taken branch together ahead of PC_en: the jump wins.
      idle_cycle(1'b1, 32'h0000_0100, 1'b1, 1'b1, 32'h0000_0200);
      fetch(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 0, 1, 32'h0A0A_0A0A, 1'b0, 1'b0);
      fetch(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1, 0, 32'h0B0B_0B0B, 1'b0, 1'b0);

      // Branch in the PC_en cycle is bypassed; an untaken branch is not.
      fetch(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0080, 0, 0, 32'h0C0C_0C0C, 1'b0, 1'b0);
      fetch(1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0300, 0, 0, 32'h0D0D_0D0D, 1'b0, 1'b0);

      // Slow grant with PC_en pulses and stray rvalid while requesting.
      fetch(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 5, 2, 32'h0E0E_0E0E, 1'b1, 1'b0);

      // Timeout with a late rvalid, then rvalid exactly on the last cycle.
      fetch(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 0, TIMEOUT + 4, 32'hAAAA_AAAA, 1'b0, 1'b0);
      fetch(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 0, TIMEOUT - 1, 32'h5555_5555, 1'b0, 1'b0);

      // Reset in WAIT, then fetch from RESET_PC and check the wrap at the top.
      reset_mid_fetch();
      fetch(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 0, 0, 32'h1234_5678, 1'b0, 1'b0);
      idle_cycle(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
      fetch(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 0, 0, 32'h8765_4321, 1'b0, 1'b0);
      fetch(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 0, 0, 32'h0F0F_0F0F, 1'b0, 1'b0);

      // Randomized traffic, including unaligned targets and timeouts.
      for (int i = 0; i < 60; i++) begin
         int rv;
         int sel;
         sel = $urandom_range(0, 9);
         if (sel == 0)      rv = -1;
         else if (sel == 1) rv = TIMEOUT - 1;
         else if (sel == 2) rv = TIMEOUT + $urandom_range(0, 3);
         else               rv = $urandom_range(0, 5);
         if ($urandom_range(0, 3) == 0)
            idle_cycle(1'($urandom_range(0, 1)), $urandom,
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
         fetch(1'($urandom_range(0, 3) == 0), $urandom,
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), $urandom,
               $urandom_range(0, 4), rv, $urandom, 1'b1, 1'b1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_instr_fetch_unit
